// File: rtl/i2c_master_apb_ctrl.sv
// APB3 register front-end for the I2C master core: register map, command and
// read-data FIFOs, sticky status bits and a level interrupt.
module i2c_master_apb_ctrl #(
    parameter int                  APB_ABIT   = 32,
    parameter int                  APB_DBIT   = 32,
    parameter logic [APB_ABIT-1:0] BASE_ADDR  = '0,
    parameter logic [6:0]          SLAVE_ADDR = 7'h50,
    parameter int                  WR_BITS    = 1,
    parameter int                  RD_BITS    = 1,
    parameter int                  CMD_DEPTH  = 8,
    parameter int                  RX_DEPTH   = 8
) (
    input  logic                 apb_clk,
    input  logic                 apb_rst,
    input  logic                 i_apb_psel,
    input  logic                 i_apb_penable,
    input  logic                 i_apb_pwrite,
    input  logic [APB_ABIT-1:0]  i_apb_paddr,
    input  logic [APB_DBIT-1:0]  i_apb_pwdata,
    output logic                 o_apb_pready,
    output logic [APB_DBIT-1:0]  o_apb_prdata,
    output logic                 o_apb_slverr,
    output logic                 o_irq,
    output logic                 o_i2c_wvalid,
    input  logic                 i_i2c_wready,
    output logic                 o_cmd_bit_ctrl,
    output logic                 o_cmd_rh_wl,
    output logic [6:0]           o_i2c_slave,
    output logic [15:0]          o_i2c_addr,
    output logic [WR_BITS*8-1:0] o_i2c_wdata,
    input  logic [RD_BITS*8-1:0] i_i2c_rdata,
    input  logic                 i_i2c_rvalid,
    input  logic                 i_i2c_done,
    input  logic                 i_i2c_ack
);
    localparam int WR_W = WR_BITS * 8;
    localparam int RD_W = RD_BITS * 8;
    localparam int CPW  = $clog2(CMD_DEPTH);
    localparam int RPW  = $clog2(RX_DEPTH);
    localparam logic [CPW:0] CMD_ONE = {{CPW{1'b0}}, 1'b1};
    localparam logic [RPW:0] RX_ONE  = {{RPW{1'b0}}, 1'b1};

    localparam logic [2:0] OFF_CTRL   = 3'd0;
    localparam logic [2:0] OFF_STATUS = 3'd1;
    localparam logic [2:0] OFF_WDATA  = 3'd2;
    localparam logic [2:0] OFF_CMD    = 3'd3;
    localparam logic [2:0] OFF_RDATA  = 3'd4;

    typedef struct packed {
        logic            rd;
        logic            addr16;
        logic [6:0]      saddr;
        logic [15:0]     addr;
        logic [WR_W-1:0] wdata;
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    // Register state
    logic            en_q, en_d;
    logic            addr16_q, addr16_d;
    logic            irq_en_q, irq_en_d;
    logic            fon_q, fon_d;
    logic [6:0]      saddr_q, saddr_d;
    logic [WR_W-1:0] wdata_q, wdata_d;
    logic            done_q, done_d;
    logic            nack_q, nack_d;
    logic            ovf_q, ovf_d;
    state_t          state_q, state_d;
    cmd_t            cur_q, cur_d;
    logic [RD_W-1:0] rdata_q, rdata_d;

    // FIFO state
    cmd_t            cmd_mem_q [CMD_DEPTH];
    logic [RD_W-1:0] rx_mem_q  [RX_DEPTH];
    logic [CPW:0]    cmd_wptr_q, cmd_wptr_d, cmd_rptr_q, cmd_rptr_d;
    logic [RPW:0]    rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;

    logic [CPW:0]    cmd_level;
    logic            cmd_full, cmd_empty, rx_full, rx_empty;
    cmd_t            cmd_head, cmd_new;
    logic [RD_W-1:0] rx_head, rx_data;

    logic            access, sel_hit;
    logic [2:0]      offs;
    logic [31:0]     prdata, ctrl_rd, status_rd;
    logic            slverr;
    logic            ctrl_wr, stat_wr, wdata_wr, cmd_push, rx_pop, flush;
    logic            cmd_pop, rx_push, rx_push_ok, set_done, set_nack, set_ovf, nack_flush;
    logic            unused_apb;

    assign unused_apb = ^{i_apb_paddr[1:0], i_apb_pwdata};

    assign cmd_level = cmd_wptr_q - cmd_rptr_q;
    assign cmd_empty = (cmd_wptr_q == cmd_rptr_q);
    assign cmd_full  = (cmd_wptr_q[CPW] != cmd_rptr_q[CPW]) &&
                       (cmd_wptr_q[CPW-1:0] == cmd_rptr_q[CPW-1:0]);
    assign rx_empty  = (rx_wptr_q == rx_rptr_q);
    assign rx_full   = (rx_wptr_q[RPW] != rx_rptr_q[RPW]) &&
                       (rx_wptr_q[RPW-1:0] == rx_rptr_q[RPW-1:0]);
    assign cmd_head  = cmd_mem_q[cmd_rptr_q[CPW-1:0]];
    assign rx_head   = rx_mem_q[rx_rptr_q[RPW-1:0]];

    assign access  = i_apb_psel & i_apb_penable;
    assign sel_hit = (i_apb_paddr[APB_ABIT-1:5] == BASE_ADDR[APB_ABIT-1:5]);
    assign offs    = i_apb_paddr[4:2];

    always_comb begin
        ctrl_rd        = '0;
        ctrl_rd[0]     = en_q;
        ctrl_rd[1]     = addr16_q;
        ctrl_rd[2]     = irq_en_q;
        ctrl_rd[3]     = fon_q;
        ctrl_rd[14:8]  = saddr_q;

        status_rd        = '0;
        status_rd[0]     = (state_q != ST_IDLE);
        status_rd[1]     = cmd_full;
        status_rd[2]     = cmd_empty;
        status_rd[3]     = rx_empty;
        status_rd[4]     = rx_full;
        status_rd[8]     = done_q;
        status_rd[9]     = nack_q;
        status_rd[10]    = ovf_q;
        status_rd[23:16] = 8'(cmd_level);
    end

    // APB decode: every side effect is qualified here so an erroring access has none.
    always_comb begin
        prdata   = '0;
        slverr   = 1'b0;
        ctrl_wr  = 1'b0;
        stat_wr  = 1'b0;
        wdata_wr = 1'b0;
        cmd_push = 1'b0;
        rx_pop   = 1'b0;
        if (access) begin
            if (!sel_hit) begin
                slverr = 1'b1;
            end else begin
                case (offs)
                    OFF_CTRL: begin
                        if (i_apb_pwrite) ctrl_wr = 1'b1;
                        else              prdata  = ctrl_rd;
                    end
                    OFF_STATUS: begin
                        if (i_apb_pwrite) stat_wr = 1'b1;
                        else              prdata  = status_rd;
                    end
                    OFF_WDATA: begin
                        if (i_apb_pwrite) wdata_wr = 1'b1;
                        else              prdata   = 32'(wdata_q);
                    end
                    OFF_CMD: begin
                        if (i_apb_pwrite) begin
                            if (cmd_full) slverr   = 1'b1;
                            else          cmd_push = 1'b1;
                        end
                    end
                    OFF_RDATA: begin
                        if (!i_apb_pwrite) begin
                            if (rx_empty) begin
                                slverr = 1'b1;
                            end else begin
                                rx_pop = 1'b1;
                                prdata = 32'(rx_head);
                            end
                        end
                    end
                    default: slverr = 1'b1;
                endcase
            end
        end
    end

    assign flush = ctrl_wr & i_apb_pwdata[31];

    always_comb begin
        cmd_new.rd     = i_apb_pwdata[16];
        cmd_new.addr16 = addr16_q;
        cmd_new.saddr  = saddr_q;
        cmd_new.addr   = i_apb_pwdata[15:0];
        cmd_new.wdata  = wdata_q;
    end

    // Dispatcher. The issued command is captured into cur_q on entry to ISSUE
    // so a flush cannot disturb the fields while the core is looking at them.
    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        rdata_d    = rdata_q;
        rx_data    = rdata_q;
        cmd_pop    = 1'b0;
        rx_push    = 1'b0;
        set_done   = 1'b0;
        set_nack   = 1'b0;
        nack_flush = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en_q && !cmd_empty) begin
                    state_d = ST_ISSUE;
                    cur_d   = cmd_head;
                end
            end
            ST_ISSUE: begin
                if (i_i2c_wready) begin
                    cmd_pop = !cmd_empty;
                    rdata_d = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (i_i2c_rvalid) begin
                    rdata_d = i_i2c_rdata;
                    rx_data = i_i2c_rdata;
                end
                if (i_i2c_done) begin
                    rx_push    = cur_q.rd;
                    set_done   = 1'b1;
                    set_nack   = i_i2c_ack;
                    nack_flush = i_i2c_ack & fon_q;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A pop in the same cycle frees the slot, so a full RX FIFO still accepts.
    assign rx_push_ok = rx_push & (~rx_full | rx_pop | flush);
    assign set_ovf    = rx_push & ~rx_push_ok;

    always_comb begin
        en_d     = en_q;
        addr16_d = addr16_q;
        irq_en_d = irq_en_q;
        fon_d    = fon_q;
        saddr_d  = saddr_q;
        wdata_d  = wdata_q;
        if (ctrl_wr) begin
            en_d     = i_apb_pwdata[0];
            addr16_d = i_apb_pwdata[1];
            irq_en_d = i_apb_pwdata[2];
            fon_d    = i_apb_pwdata[3];
            saddr_d  = i_apb_pwdata[14:8];
        end
        if (wdata_wr) wdata_d = i_apb_pwdata[WR_W-1:0];

        done_d = (done_q & ~(stat_wr & i_apb_pwdata[8]))  | set_done;
        nack_d = (nack_q & ~(stat_wr & i_apb_pwdata[9]))  | set_nack;
        ovf_d  = (ovf_q  & ~(stat_wr & i_apb_pwdata[10])) | set_ovf;

        cmd_wptr_d = cmd_push ? cmd_wptr_q + CMD_ONE : cmd_wptr_q;
        cmd_rptr_d = cmd_pop  ? cmd_rptr_q + CMD_ONE : cmd_rptr_q;
        if (flush || nack_flush) cmd_rptr_d = cmd_wptr_q;

        rx_wptr_d = rx_push_ok ? rx_wptr_q + RX_ONE : rx_wptr_q;
        rx_rptr_d = rx_pop     ? rx_rptr_q + RX_ONE : rx_rptr_q;
        if (flush) rx_rptr_d = rx_wptr_q;
    end

    always_ff @(posedge apb_clk) begin
        if (cmd_push)   cmd_mem_q[cmd_wptr_q[CPW-1:0]] <= cmd_new;
        if (rx_push_ok) rx_mem_q[rx_wptr_q[RPW-1:0]]   <= rx_data;
    end

    always_ff @(posedge apb_clk or posedge apb_rst) begin
        if (apb_rst) begin
            en_q         <= 1'b0;
            addr16_q     <= 1'b0;
            irq_en_q     <= 1'b0;
            fon_q        <= 1'b0;
            saddr_q      <= SLAVE_ADDR;
            wdata_q      <= '0;
            done_q       <= 1'b0;
            nack_q       <= 1'b0;
            ovf_q        <= 1'b0;
            state_q      <= ST_IDLE;
            cur_q.rd     <= 1'b0;
            cur_q.addr16 <= 1'b0;
            cur_q.saddr  <= SLAVE_ADDR;
            cur_q.addr   <= '0;
            cur_q.wdata  <= '0;
            rdata_q      <= '0;
            cmd_wptr_q   <= '0;
            cmd_rptr_q   <= '0;
            rx_wptr_q    <= '0;
            rx_rptr_q    <= '0;
        end else begin
            en_q       <= en_d;
            addr16_q   <= addr16_d;
            irq_en_q   <= irq_en_d;
            fon_q      <= fon_d;
            saddr_q    <= saddr_d;
            wdata_q    <= wdata_d;
            done_q     <= done_d;
            nack_q     <= nack_d;
            ovf_q      <= ovf_d;
            state_q    <= state_d;
            cur_q      <= cur_d;
            rdata_q    <= rdata_d;
            cmd_wptr_q <= cmd_wptr_d;
            cmd_rptr_q <= cmd_rptr_d;
            rx_wptr_q  <= rx_wptr_d;
            rx_rptr_q  <= rx_rptr_d;
        end
    end

    assign o_apb_pready   = 1'b1;
    assign o_apb_prdata   = prdata;
    assign o_apb_slverr   = slverr;
    assign o_irq          = irq_en_q & (done_q | nack_q | ovf_q);
    assign o_i2c_wvalid   = (state_q == ST_ISSUE);
    assign o_cmd_bit_ctrl = cur_q.addr16;
    assign o_cmd_rh_wl    = cur_q.rd;
    assign o_i2c_slave    = cur_q.saddr;
    assign o_i2c_addr     = cur_q.addr;
    assign o_i2c_wdata    = cur_q.wdata;

endmodule
